// File: rtl/yon_denetleyici.sv
// yon_denetleyici: debounced direction controller for the obstacle-sensing vehicle.
// Raw sensors are synchronised and filtered, reduced to a 2-bit direction request,
// and a state machine enforces minimum turn time, bounded reversing and a latched halt.
module yon_denetleyici #(
    parameter int FILTRE     = 4,
    parameter int DONUS      = 16,
    parameter int GERI       = 8,
    parameter int MAX_DENEME = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sag,
    input  logic       sol,
    input  logic       on,
    input  logic       temizle,
    output logic [1:0] yon,
    output logic       degisti,
    output logic       dur
);

    // Counter widths
    localparam int FW        = $clog2(FILTRE + 1);
    localparam int SAYAC_UST = (DONUS > GERI) ? DONUS : GERI;
    localparam int SW        = $clog2(SAYAC_UST + 1);
    localparam int DW        = $clog2(MAX_DENEME + 1);

    // Bit order for the sensor vectors: [0]=sag, [1]=sol, [2]=on
    logic [2:0]    ham;
    logic [2:0]    senk1;
    logic [2:0]    senk2;
    logic [2:0]    filtre_q;
    logic [FW-1:0] fark_say [3];
    logic [1:0]    istek;

    assign ham = {on, sol, sag};

    // Two-flop synchroniser for the asynchronous sensor pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            senk1 <= '0;
            senk2 <= '0;
        end else begin
            senk1 <= ham;
            senk2 <= senk1;
        end
    end

    // Per-input debounce: filtered value flips after FILTRE consecutive mismatches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filtre_q <= '0;
            for (int i = 0; i < 3; i++) begin
                fark_say[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (senk2[i] == filtre_q[i]) begin
                    fark_say[i] <= '0;
                end else if (fark_say[i] == FW'(FILTRE - 1)) begin
                    filtre_q[i] <= senk2[i];
                    fark_say[i] <= '0;
                end else begin
                    fark_say[i] <= fark_say[i] + FW'(1);
                end
            end
        end
    end

    // Direction request, same code as the combinational decoder
    assign istek[1] = filtre_q[2] | (filtre_q[1] & ~filtre_q[0]);
    assign istek[0] = filtre_q[2] | filtre_q[0];

    typedef enum logic [2:0] {
        D_ILERI     = 3'd0,
        D_SAG_ENGEL = 3'd1,
        D_SOL_ENGEL = 3'd2,
        D_GERI      = 3'd3,
        D_DUR       = 3'd4
    } durum_t;

    durum_t        durum;
    durum_t        sonraki;
    durum_t        hedef;
    durum_t        geri_hedefi;
    logic          giris;
    logic [SW-1:0] sayac;
    logic [DW-1:0] deneme;
    logic [DW-1:0] deneme_sonraki;
    logic [1:0]    yon_sonraki;

    // Next-state decision: dispatch targets, hold expiry, front-obstacle preemption
    always_comb begin
        geri_hedefi = (deneme == DW'(MAX_DENEME)) ? D_DUR : D_GERI;
        case (istek)
            2'b00:   hedef = D_ILERI;
            2'b01:   hedef = D_SAG_ENGEL;
            2'b10:   hedef = D_SOL_ENGEL;
            default: hedef = geri_hedefi;
        endcase

        sonraki = durum;
        giris   = 1'b0;
        case (durum)
            D_ILERI: begin
                sonraki = hedef;
                giris   = (hedef != D_ILERI);
            end
            D_SAG_ENGEL, D_SOL_ENGEL: begin
                if (istek == 2'b11) begin
                    sonraki = geri_hedefi;
                    giris   = 1'b1;
                end else if (sayac == SW'(DONUS - 1)) begin
                    sonraki = hedef;
                    giris   = 1'b1;
                end
            end
            D_GERI: begin
                if (sayac == SW'(GERI - 1)) begin
                    sonraki = hedef;
                    giris   = 1'b1;
                end
            end
            D_DUR: begin
                if (temizle) begin
                    sonraki = D_ILERI;
                    giris   = 1'b1;
                end
            end
            default: begin
                sonraki = D_ILERI;
                giris   = 1'b1;
            end
        endcase

        // Reverse episodes count up until the vehicle gets back to forward motion
        if (sonraki == D_ILERI) begin
            deneme_sonraki = '0;
        end else if (giris && (sonraki == D_GERI)) begin
            deneme_sonraki = deneme + DW'(1);
        end else begin
            deneme_sonraki = deneme;
        end

        case (sonraki)
            D_SAG_ENGEL: yon_sonraki = 2'b01;
            D_SOL_ENGEL: yon_sonraki = 2'b10;
            D_GERI:      yon_sonraki = 2'b11;
            default:     yon_sonraki = 2'b00;
        endcase
    end

    // State register with registered outputs; the hold counter restarts on every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum   <= D_ILERI;
            sayac   <= '0;
            deneme  <= '0;
            yon     <= 2'b00;
            degisti <= 1'b0;
            dur     <= 1'b0;
        end else begin
            durum  <= sonraki;
            deneme <= deneme_sonraki;
            if (giris) begin
                sayac <= '0;
            end else if (sayac != SW'(SAYAC_UST)) begin
                sayac <= sayac + SW'(1);
            end
            yon     <= yon_sonraki;
            degisti <= (yon_sonraki != yon);
            dur     <= (sonraki == D_DUR);
        end
    end

endmodule

// File: tb/tb_yon_denetleyici.sv
// Bench for yon_denetleyici: directed scenarios plus a randomized run, every cycle
// compared against a timestamp-based behavioural model of the controller.
module tb_yon_denetleyici;

    localparam int FILTRE     = 4;
    localparam int DONUS      = 16;
    localparam int GERI       = 8;
    localparam int MAX_DENEME = 3;

    localparam int M_FWD  = 0;
    localparam int M_SAG  = 1;
    localparam int M_SOL  = 2;
    localparam int M_REV  = 3;
    localparam int M_HALT = 4;

    logic       clk;
    logic       rst_n;
    logic       sag;
    logic       sol;
    logic       on;
    logic       temizle;
    logic [1:0] yon;
    logic       degisti;
    logic       dur;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model variables
    int         m_n;
    logic [2:0] m_s1;
    logic [2:0] m_s2;
    logic [2:0] m_f;
    int         m_run [3];
    int         m_mode;
    int         m_entry;
    int         m_ep;
    logic [1:0] m_yon;
    logic       m_deg;
    logic       m_dur;

    // Scenario scratch variables
    logic [1:0] tt_exp;
    logic       any_deg;
    int         cnt;
    int         lat;
    int         guard;
    int         seg_len;

    yon_denetleyici #(
        .FILTRE     (FILTRE),
        .DONUS      (DONUS),
        .GERI       (GERI),
        .MAX_DENEME (MAX_DENEME)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sag     (sag),
        .sol     (sol),
        .on      (on),
        .temizle (temizle),
        .yon     (yon),
        .degisti (degisti),
        .dur     (dur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] yon_of(input int mode);
        case (mode)
            M_SAG:   return 2'b01;
            M_SOL:   return 2'b10;
            M_REV:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int rev_target();
        return (m_ep >= MAX_DENEME) ? M_HALT : M_REV;
    endfunction

    function automatic int dispatch(input logic [1:0] req);
        case (req)
            2'b00:   return M_FWD;
            2'b01:   return M_SAG;
            2'b10:   return M_SOL;
            default: return rev_target();
        endcase
    endfunction

    task automatic model_reset();
        m_s1   = '0;
        m_s2   = '0;
        m_f    = '0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        m_mode  = M_FWD;
        m_entry = m_n;
        m_ep    = 0;
        m_yon   = 2'b00;
        m_deg   = 1'b0;
        m_dur   = 1'b0;
    endtask

    // One rising edge of the model, using the inputs the DUT sampled at that edge
    task automatic model_step();
        logic [1:0] req;
        int         nm;
        bit         ent;
        m_n++;
        req = {m_f[2] | (m_f[1] & ~m_f[0]), m_f[2] | m_f[0]};
        nm  = m_mode;
        ent = 0;
        case (m_mode)
            M_FWD: begin
                nm  = dispatch(req);
                ent = (nm != M_FWD);
            end
            M_SAG, M_SOL: begin
                if (req == 2'b11) begin
                    nm  = rev_target();
                    ent = 1;
                end else if (m_n - m_entry >= DONUS) begin
                    nm  = dispatch(req);
                    ent = 1;
                end
            end
            M_REV: begin
                if (m_n - m_entry >= GERI) begin
                    nm  = dispatch(req);
                    ent = 1;
                end
            end
            default: begin
                if (temizle) begin
                    nm  = M_FWD;
                    ent = 1;
                end
            end
        endcase
        if (ent) m_entry = m_n;
        if (nm == M_FWD) m_ep = 0;
        else if (ent && nm == M_REV) m_ep++;
        m_deg  = (yon_of(nm) != m_yon);
        m_yon  = yon_of(nm);
        m_dur  = (nm == M_HALT);
        m_mode = nm;
        // Debounce on the synchronised sample seen at this edge
        for (int i = 0; i < 3; i++) begin
            if (m_s2[i] != m_f[i]) begin
                m_run[i]++;
                if (m_run[i] == FILTRE) begin
                    m_f[i]   = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = {on, sol, sag};
    endtask

    // Advance one clock, update the model, then compare away from the edge
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        chk("yon", yon, m_yon);
        chk("degisti", {1'b0, degisti}, {1'b0, m_deg});
        chk("dur", {1'b0, dur}, {1'b0, m_dur});
    endtask

    task automatic do_reset();
        sag     = 1'b0;
        sol     = 1'b0;
        on      = 1'b0;
        temizle = 1'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        m_n     = 0;
        rst_n   = 1'b0;
        sag     = 1'b0;
        sol     = 1'b0;
        on      = 1'b0;
        temizle = 1'b0;
        model_reset();

        // Reset values before any clock edge
        #2;
        chk("rst_yon", yon, 2'b00);
        chk("rst_degisti", {1'b0, degisti}, 2'b00);
        chk("rst_dur", {1'b0, dur}, 2'b00);
        tick();
        tick();
        rst_n = 1'b1;

        // Static truth table, each combination from a fresh reset
        for (int c = 0; c < 8; c++) begin
            do_reset();
            {on, sol, sag} = c[2:0];
            if (c[2])      tt_exp = 2'b11;
            else if (c[0]) tt_exp = 2'b01;
            else if (c[1]) tt_exp = 2'b10;
            else           tt_exp = 2'b00;
            for (int k = 1; k <= 40; k++) begin
                tick();
                if (k == 6) chk("tt_early_yon", yon, 2'b00);
                if (k == 7) begin
                    chk("tt_yon", yon, tt_exp);
                    chk("tt_degisti", {1'b0, degisti}, {1'b0, tt_exp != 2'b00});
                end
            end
        end

        // Glitch shorter than the filter length
        do_reset();
        sag = 1'b1;
        repeat (3) tick();
        sag = 1'b0;
        any_deg = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            any_deg = any_deg | degisti;
        end
        chk("glitch_yon", yon, 2'b00);
        chk("glitch_degisti", {1'b0, any_deg}, 2'b00);

        // Latency of a held sensor, then the minimum turn hold
        sag = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) chk("lat_early_yon", yon, 2'b00);
        end
        chk("lat_yon", yon, 2'b01);
        chk("lat_degisti", {1'b0, degisti}, 2'b01);
        cnt = 1;
        for (int k = 0; k < 40; k++) begin
            if (k == 2) sag = 1'b0;
            tick();
            if (yon == 2'b01) cnt++;
        end
        chk_int("hold_len", cnt, DONUS);
        chk("hold_end_yon", yon, 2'b00);

        // Front obstacle preempting a turn
        do_reset();
        sag = 1'b1;
        repeat (7) tick();
        chk("pre_turn_yon", yon, 2'b01);
        on  = 1'b1;
        lat = 0;
        guard = 0;
        while (lat == 0 && guard < 12) begin
            guard++;
            tick();
            if (yon == 2'b11) lat = guard;
        end
        chk_int("pre_latency", lat, 7);
        on  = 1'b0;
        cnt = 1;
        guard = 0;
        while (yon == 2'b11 && guard < 20) begin
            guard++;
            tick();
            if (yon == 2'b11) cnt++;
        end
        chk_int("pre_geri_len", cnt, GERI);
        chk("pre_after_yon", yon, 2'b01);
        sag = 1'b0;
        repeat (30) tick();

        // Continuous front obstacle: three reverse episodes, then halt
        do_reset();
        on  = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (yon == 2'b11) cnt++;
            if (k == 30) chk("rev_last_yon", yon, 2'b11);
            if (k == 31) begin
                chk("halt_yon", yon, 2'b00);
                chk("halt_dur", {1'b0, dur}, 2'b01);
                chk("halt_degisti", {1'b0, degisti}, 2'b01);
            end
        end
        chk_int("rev_total", cnt, MAX_DENEME * GERI);
        chk("halt_hold_dur", {1'b0, dur}, 2'b01);
        temizle = 1'b1;
        tick();
        temizle = 1'b0;
        chk("clear_dur", {1'b0, dur}, 2'b00);
        chk("clear_degisti", {1'b0, degisti}, 2'b00);
        tick();
        chk("clear_regeri_yon", yon, 2'b11);
        chk("clear_regeri_degisti", {1'b0, degisti}, 2'b01);

        // Asynchronous reset in the middle of a reverse episode
        repeat (3) tick();
        chk("mid_geri_yon", yon, 2'b11);
        #3;
        rst_n = 1'b0;
        on    = 1'b0;
        #1;
        chk("async_yon", yon, 2'b00);
        chk("async_degisti", {1'b0, degisti}, 2'b00);
        chk("async_dur", {1'b0, dur}, 2'b00);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        any_deg = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            any_deg = any_deg | degisti;
        end
        chk("post_rst_yon", yon, 2'b00);
        chk("post_rst_degisti", {1'b0, any_deg}, 2'b00);

        // Randomized sensor segments with sporadic clear requests
        do_reset();
        for (int seg = 0; seg < 80; seg++) begin
            sag     = 1'($urandom_range(0, 1));
            sol     = 1'($urandom_range(0, 1));
            on      = ($urandom_range(0, 3) == 0);
            seg_len = $urandom_range(1, 30);
            for (int k = 0; k < seg_len; k++) begin
                temizle = ($urandom_range(0, 7) == 0);
                tick();
            end
            temizle = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
